// File: rtl/opimm_sequencer.sv
// Multi-cycle RV32I OP-IMM sequencer: fetch, decode, execute, writeback, trap.
// Optional retired-instruction counter enabled by defining RETIRE_COUNT_EN.
module opimm_sequencer #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_valid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instruction,
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [2:0]  i_funct3,
  input  logic [4:0]  i_rs1,
  input  logic [11:0] i_immediate,
  output logic [4:0]  o_rf_raddr,
  input  logic [31:0] i_rf_rdata,
  output logic        o_rf_we,
  output logic [4:0]  o_rf_waddr,
  output logic [31:0] o_rf_wdata,
  output logic [31:0] o_pc,
  output logic        o_busy,
  output logic        o_trap,
  output logic [1:0]  o_trap_cause
`ifdef RETIRE_COUNT_EN
  ,
  output logic [31:0] o_retired
`endif
);

  localparam logic [6:0]  OPIMM     = 7'b0010011;
  localparam int unsigned CW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXECUTE,
    WRITEBACK,
    TRAP
  } state_t;

  state_t        state, next_state;
  logic [31:0]   pc_q;
  logic [31:0]   instr_q;
  logic [4:0]    rd_q;
  logic [4:0]    rs1_q;
  logic [2:0]    funct3_q;
  logic [11:0]   imm_q;
  logic [31:0]   result_q;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    cause_q;
  logic [31:0]   sext;
  logic [31:0]   exec_result;
  logic          exec_illegal;
`ifdef RETIRE_COUNT_EN
  logic [31:0]   retired_q;
`endif

  // ALU for the latched OP-IMM fields; also flags reserved shift encodings
  always_comb begin
    sext         = {{20{imm_q[11]}}, imm_q};
    exec_result  = '0;
    exec_illegal = 1'b0;
    unique case (funct3_q)
      3'b000: exec_result = i_rf_rdata + sext;
      3'b010: exec_result = {31'b0, $signed(i_rf_rdata) < $signed(sext)};
      3'b011: exec_result = {31'b0, i_rf_rdata < sext};
      3'b100: exec_result = i_rf_rdata ^ sext;
      3'b110: exec_result = i_rf_rdata | sext;
      3'b111: exec_result = i_rf_rdata & sext;
      3'b001: begin
        exec_result  = i_rf_rdata << imm_q[4:0];
        exec_illegal = (imm_q[11:5] != 7'b0000000);
      end
      3'b101: begin
        if (imm_q[11:5] == 7'b0000000) begin
          exec_result = i_rf_rdata >> imm_q[4:0];
        end else if (imm_q[11:5] == 7'b0100000) begin
          exec_result = $unsigned($signed(i_rf_rdata) >>> imm_q[4:0]);
        end else begin
          exec_illegal = 1'b1;
        end
      end
      default: exec_result = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      if (i_start) next_state = FETCH;
      FETCH: begin
        if (i_imem_valid)               next_state = DECODE;
        else if (wait_cnt == LAST_WAIT) next_state = TRAP;
      end
      DECODE:    next_state = (i_opcode != OPIMM) ? TRAP : EXECUTE;
      EXECUTE:   next_state = exec_illegal ? TRAP : WRITEBACK;
      WRITEBACK: next_state = FETCH;
      TRAP:      next_state = TRAP;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    o_imem_req = (state == FETCH);
    o_busy     = (state != IDLE) && (state != TRAP);
    o_trap     = (state == TRAP);
    o_rf_we    = (state == WRITEBACK) && (rd_q != 5'd0);
    o_rf_waddr = (state == WRITEBACK) ? rd_q : '0;
    o_rf_wdata = (state == WRITEBACK) ? result_q : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      funct3_q  <= '0;
      imm_q     <= '0;
      result_q  <= '0;
      wait_cnt  <= '0;
      cause_q   <= '0;
`ifdef RETIRE_COUNT_EN
      retired_q <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: wait_cnt <= '0;
        FETCH: begin
          if (i_imem_valid) begin
            instr_q <= i_imem_rdata;
          end else if (wait_cnt == LAST_WAIT) begin
            cause_q <= 2'd2;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DECODE: begin
          if (i_opcode != OPIMM) begin
            cause_q <= 2'd1;
          end else begin
            rd_q     <= i_rd;
            rs1_q    <= i_rs1;
            funct3_q <= i_funct3;
            imm_q    <= i_immediate;
          end
        end
        EXECUTE: begin
          if (exec_illegal) cause_q <= 2'd1;
          else              result_q <= exec_result;
        end
        WRITEBACK: begin
          pc_q      <= pc_q + 32'd4;
          wait_cnt  <= '0;
`ifdef RETIRE_COUNT_EN
          retired_q <= retired_q + 32'd1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign o_pc          = pc_q;
  assign o_imem_addr   = pc_q;
  assign o_instruction = instr_q;
  assign o_rf_raddr    = rs1_q;
  assign o_trap_cause  = cause_q;
`ifdef RETIRE_COUNT_EN
  assign o_retired     = retired_q;
`endif

endmodule

// File: tb/tb_opimm_sequencer.sv
// Scoreboard bench for opimm_sequencer: memory/RF environment, reference model, monitor.
module tb_opimm_sequencer;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_valid;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_instruction;
  logic [6:0]  i_opcode;
  logic [4:0]  i_rd;
  logic [2:0]  i_funct3;
  logic [4:0]  i_rs1;
  logic [11:0] i_immediate;
  logic [4:0]  o_rf_raddr;
  logic [31:0] i_rf_rdata;
  logic        o_rf_we;
  logic [4:0]  o_rf_waddr;
  logic [31:0] o_rf_wdata;
  logic [31:0] o_pc;
  logic        o_busy;
  logic        o_trap;
  logic [1:0]  o_trap_cause;
`ifdef RETIRE_COUNT_EN
  logic [31:0] o_retired;
`endif

  opimm_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_valid(i_imem_valid), .i_imem_rdata(i_imem_rdata),
    .o_instruction(o_instruction),
    .i_opcode(i_opcode), .i_rd(i_rd), .i_funct3(i_funct3), .i_rs1(i_rs1),
    .i_immediate(i_immediate),
    .o_rf_raddr(o_rf_raddr), .i_rf_rdata(i_rf_rdata),
    .o_rf_we(o_rf_we), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
    .o_pc(o_pc), .o_busy(o_busy), .o_trap(o_trap), .o_trap_cause(o_trap_cause)
`ifdef RETIRE_COUNT_EN
    , .o_retired(o_retired)
`endif
  );

  typedef struct {
    bit          is_trap;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [1:0]  cause;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] imem[256];
  logic [31:0] rf_init[32];
  logic [31:0] rf[32];
  int          wait_cfg;
  bit          mute;
  int          n_checks;
  int          n_fail;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Combinational decoder and register-file read port
  assign i_opcode    = o_instruction[6:0];
  assign i_rd        = o_instruction[11:7];
  assign i_funct3    = o_instruction[14:12];
  assign i_rs1       = o_instruction[19:15];
  assign i_immediate = o_instruction[31:20];
  assign i_rf_rdata  = rf[o_rf_raddr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model of one OP-IMM operation from the ISA definition
  function automatic logic [31:0] ref_exec(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [11:0] imm);
    logic [31:0] b;
    logic [31:0] ones;
    int          sa, sb;
    int unsigned sh;
    b    = {{20{imm[11]}}, imm};
    ones = '1;
    sa   = a;
    sb   = b;
    sh   = imm[4:0];
    case (f3)
      3'd0: return a + b;
      3'd1: return a << sh;
      3'd2: return (sa < sb) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return imm[10] ? ((a >> sh) | (a[31] ? ~(ones >> sh) : 32'd0)) : (a >> sh);
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [31:0] ins);
    if (ins[6:0] != 7'h13) return 1'b0;
    if (ins[14:12] == 3'd1) return ins[31:25] == 7'h00;
    if (ins[14:12] == 3'd5) return (ins[31:25] == 7'h00) || (ins[31:25] == 7'h20);
    return 1'b1;
  endfunction

  task automatic model_program();
    logic [31:0] m[32];
    logic [31:0] ins;
    logic [31:0] res;
    exp_t        e;
    for (int r = 0; r < 32; r++) m[r] = rf_init[r];
    for (int k = 0; k < 256; k++) begin
      ins     = imem[k];
      e.pc    = 32'(k * 4);
      e.cause = 2'd0;
      if (!ref_legal(ins)) begin
        e.is_trap = 1'b1;
        e.cause   = 2'd1;
        e.waddr   = '0;
        e.wdata   = '0;
        expq.push_back(e);
        return;
      end
      res = ref_exec(ins[14:12], m[ins[19:15]], ins[31:20]);
      if (ins[11:7] != 5'd0) begin
        e.is_trap = 1'b0;
        e.waddr   = ins[11:7];
        e.wdata   = res;
        expq.push_back(e);
        m[ins[11:7]] = res;
      end
    end
  endtask

  function automatic logic [31:0] rand_legal();
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [4:0]  rd, rs1;
    f3  = 3'($urandom);
    imm = 12'($urandom);
    rd  = 5'($urandom);
    rs1 = 5'($urandom);
    if ($urandom_range(7, 0) == 0) rd = 5'd0;
    if ($urandom_range(5, 0) == 0) imm = ($urandom_range(1, 0) == 1) ? 12'h800 : 12'h7FF;
    if (f3 == 3'd1) imm[11:5] = 7'h00;
    if (f3 == 3'd5) imm[11:5] = ($urandom_range(1, 0) == 1) ? 7'h20 : 7'h00;
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  function automatic logic [31:0] rand_term();
    logic [31:0] ins;
    logic [6:0]  hi;
    ins = $urandom;
    hi  = 7'($urandom);
    case ($urandom_range(2, 0))
      0: if (ins[6:0] == 7'h13) ins[6:0] = 7'h33;
      1: begin
        if (hi == 7'h00) hi = 7'h01;
        ins = {hi, ins[24:15], 3'd1, ins[11:7], 7'h13};
      end
      default: begin
        if (hi == 7'h00 || hi == 7'h20) hi = 7'h7F;
        ins = {hi, ins[24:15], 3'd5, ins[11:7], 7'h13};
      end
    endcase
    return ins;
  endfunction

  // Environment: instruction memory with programmable wait states and the register file
  initial begin
    int wcnt;
    bit in_fetch;
    i_imem_valid = 1'b0;
    i_imem_rdata = '0;
    in_fetch     = 1'b0;
    wcnt         = 0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        for (int r = 0; r < 32; r++) rf[r] = rf_init[r];
      end else if (o_rf_we) begin
        rf[o_rf_waddr] = o_rf_wdata;
      end
      if (!i_rst_n || !o_imem_req) begin
        i_imem_valid = 1'b0;
        in_fetch     = 1'b0;
      end else begin
        if (!in_fetch) begin
          in_fetch = 1'b1;
          wcnt     = (wait_cfg < 0) ? int'($urandom_range(3, 0)) : wait_cfg;
        end
        if (!mute && wcnt == 0) begin
          i_imem_valid = 1'b1;
          i_imem_rdata = imem[o_imem_addr[9:2]];
        end else begin
          i_imem_valid = 1'b0;
          i_imem_rdata = $urandom;
          if (wcnt > 0) wcnt--;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every register write and on trap entry
  initial begin
    exp_t e;
    bit   trap_seen;
    trap_seen = 1'b0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        trap_seen = 1'b0;
        continue;
      end
      if (o_rf_we) begin
        if (expq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got x%0d=%h expected no write", o_rf_waddr, o_rf_wdata);
        end else begin
          e = expq.pop_front();
          chk("write_not_trap", {31'b0, e.is_trap}, 32'd0);
          chk("wb_waddr", {27'b0, o_rf_waddr}, {27'b0, e.waddr});
          chk("wb_wdata", o_rf_wdata, e.wdata);
          chk("wb_pc", o_pc, e.pc);
        end
      end
      if (o_trap && !trap_seen) begin
        trap_seen = 1'b1;
        if (expq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_trap: got cause %0d expected no trap", o_trap_cause);
        end else begin
          e = expq.pop_front();
          chk("trap_expected", {31'b0, e.is_trap}, 32'd1);
          chk("trap_cause", {30'b0, o_trap_cause}, {30'b0, e.cause});
          chk("trap_pc", o_pc, e.pc);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    i_start = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic start_run();
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic wait_trap(input int limit);
    int c;
    c = 0;
    while (!o_trap && c < limit) begin
      @(negedge i_clk);
      c++;
    end
    chk("trap_reached", {31'b0, o_trap}, 32'd1);
    @(negedge i_clk);
    chk("queue_drained", 32'(expq.size()), 32'd0);
    expq.delete();
  endtask

  task automatic fill_env();
    for (int k = 0; k < 256; k++) imem[k] = 32'h0000_0033;
    for (int r = 0; r < 32; r++) rf_init[r] = (r == 0) ? 32'd0 : $urandom;
  endtask

  // Single instruction at address 0 followed by an illegal opcode, zero-wait memory
  task automatic directed_single(input logic [31:0] ins, input logic [4:0] src,
                                 input logic [31:0] src_val, input logic we,
                                 input logic [4:0] waddr, input logic [31:0] wdata);
    fill_env();
    wait_cfg     = 0;
    imem[0]      = ins;
    rf_init[src] = src_val;
    do_reset();
    model_program();
    start_run();
    chk("d_req", {31'b0, o_imem_req}, 32'd1);
    chk("d_addr0", o_imem_addr, 32'd0);
    repeat (3) @(negedge i_clk);
    chk("d_we", {31'b0, o_rf_we}, {31'b0, we});
    if (we) begin
      chk("d_waddr", {27'b0, o_rf_waddr}, {27'b0, waddr});
      chk("d_wdata", o_rf_wdata, wdata);
    end
    chk("d_pc_wb", o_pc, 32'd0);
    @(negedge i_clk);
    chk("d_pc_next", o_pc, 32'd4);
    chk("d_addr_next", o_imem_addr, 32'd4);
    chk("d_req_next", {31'b0, o_imem_req}, 32'd1);
`ifdef RETIRE_COUNT_EN
    chk("d_retired", o_retired, 32'd1);
`endif
    wait_trap(40);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    wait_cfg = 0;
    mute     = 1'b0;
    i_rst_n  = 1'b0;
    i_start  = 1'b0;
    fill_env();

    // Reset state
    repeat (2) @(negedge i_clk);
    chk("rst_pc", o_pc, 32'd0);
    chk("rst_instr", o_instruction, 32'd0);
    chk("rst_req", {31'b0, o_imem_req}, 32'd0);
    chk("rst_we", {31'b0, o_rf_we}, 32'd0);
    chk("rst_waddr", {27'b0, o_rf_waddr}, 32'd0);
    chk("rst_wdata", o_rf_wdata, 32'd0);
    chk("rst_raddr", {27'b0, o_rf_raddr}, 32'd0);
    chk("rst_busy", {31'b0, o_busy}, 32'd0);
    chk("rst_trap", {31'b0, o_trap}, 32'd0);
    chk("rst_cause", {30'b0, o_trap_cause}, 32'd0);
`ifdef RETIRE_COUNT_EN
    chk("rst_retired", o_retired, 32'd0);
`endif
    i_rst_n = 1'b1;

    directed_single(32'h0000_0013, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    directed_single(32'h0010_8093, 5'd1, 32'd5, 1'b1, 5'd1, 32'd6);
    directed_single(32'hFFFF_8113, 5'd31, 32'd0, 1'b1, 5'd2, 32'hFFFF_FFFF);

    // Three wait states before valid
    fill_env();
    wait_cfg   = 3;
    imem[0]    = 32'h0010_8093;
    rf_init[1] = 32'd5;
    do_reset();
    model_program();
    start_run();
    for (int c = 0; c < 4; c++) begin
      chk("w_req", {31'b0, o_imem_req}, 32'd1);
      chk("w_addr", o_imem_addr, 32'd0);
      chk("w_instr_held", o_instruction, 32'd0);
      @(negedge i_clk);
    end
    chk("w_instr_latched", o_instruction, 32'h0010_8093);
    chk("w_req_off", {31'b0, o_imem_req}, 32'd0);
    repeat (2) @(negedge i_clk);
    chk("w_we_cycle7", {31'b0, o_rf_we}, 32'd1);
    @(negedge i_clk);
    chk("w_addr_next", o_imem_addr, 32'd4);
    wait_trap(40);

    // Illegal opcode at address 0
    fill_env();
    wait_cfg = 0;
    do_reset();
    model_program();
    start_run();
    @(negedge i_clk);
    chk("il_no_trap_in_decode", {31'b0, o_trap}, 32'd0);
    @(negedge i_clk);
    chk("il_trap", {31'b0, o_trap}, 32'd1);
    chk("il_cause", {30'b0, o_trap_cause}, 32'd1);
    chk("il_pc", o_pc, 32'd0);
    chk("il_busy", {31'b0, o_busy}, 32'd0);
    i_start = 1'b1;
    repeat (3) begin
      @(negedge i_clk);
      chk("il_sticky", {31'b0, o_trap}, 32'd1);
      chk("il_req", {31'b0, o_imem_req}, 32'd0);
      chk("il_pc_hold", o_pc, 32'd0);
    end
    i_start = 1'b0;
    chk("il_queue", 32'(expq.size()), 32'd0);
    expq.delete();

    // Fetch timeout, then asynchronous reset out of TRAP
    fill_env();
    mute = 1'b1;
    do_reset();
    expq.push_back('{is_trap: 1'b1, waddr: 5'd0, wdata: 32'd0, pc: 32'd0, cause: 2'd2});
    start_run();
    for (int c = 0; c < 16; c++) begin
      chk("to_waiting", {31'b0, o_trap}, 32'd0);
      chk("to_req", {31'b0, o_imem_req}, 32'd1);
      @(negedge i_clk);
    end
    chk("to_trap", {31'b0, o_trap}, 32'd1);
    chk("to_cause", {30'b0, o_trap_cause}, 32'd2);
    chk("to_req_off", {31'b0, o_imem_req}, 32'd0);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("to_async_trap", {31'b0, o_trap}, 32'd0);
    chk("to_async_cause", {30'b0, o_trap_cause}, 32'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    mute    = 1'b0;
    chk("to_queue", 32'(expq.size()), 32'd0);
    expq.delete();

    // Reset in the middle of a stalled fetch
    wait_cfg = 3;
    start_run();
    @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("mid_req_async", {31'b0, o_imem_req}, 32'd0);
    chk("mid_busy_async", {31'b0, o_busy}, 32'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Random programs ending in an illegal encoding
    for (int p = 0; p < 6; p++) begin
      int n;
      fill_env();
      wait_cfg = (p % 2 == 0) ? -1 : 0;
      n = $urandom_range(40, 20);
      for (int k = 0; k < n; k++) imem[k] = rand_legal();
      imem[n] = rand_term();
      do_reset();
      model_program();
      start_run();
      wait_trap(n * 8 + 40);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/opimm_sequencer.md
# opimm_sequencer

Multi-cycle control FSM that fetches RV32I instructions from instruction memory, drives the latched word into the combinational decoder, and executes OP-IMM (opcode 0010011) instructions against the register file. It sequences the fetch → decode → execute → writeback datapath around the decoder, owns the PC, and traps on any unsupported encoding or fetch timeout.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- TIMEOUT_CYCLES, 16, max FETCH cycles without i_imem_valid before trap (≥1)

- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  leave IDLE and begin fetching at o_pc; ignored outside IDLE
- o_imem_req  out  1  fetch request, high throughout FETCH
- o_imem_addr  out  32  fetch address (= o_pc)
- i_imem_valid  in  1  i_imem_rdata valid; sampled only in FETCH
- i_imem_rdata  in  32  fetched instruction
- o_instruction  out  32  latched instruction to decoder
- i_opcode, i_rd, i_funct3, i_rs1, i_immediate  in  7/5/3/5/12  decoder outputs
- o_rf_raddr  out  5  register file read address (= i_rs1 latched)
- i_rf_rdata  in  32  register file read data, combinational
- o_rf_we  out  1  write enable, one-cycle pulse
- o_rf_waddr  out  5  write address
- o_rf_wdata  out  32  write data
- o_pc  out  32  current PC
- o_busy  out  1  state ≠ IDLE and ≠ TRAP
- o_trap  out  1  sticky trap flag
- o_trap_cause  out  2  0 none, 1 illegal instruction, 2 fetch timeout

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, TRAP.
- IDLE: i_start → FETCH.
- FETCH: o_imem_req=1, addr=o_pc. i_imem_valid high (including first FETCH cycle) → latch i_imem_rdata into o_instruction, → DECODE. Wait counter reaching TIMEOUT_CYCLES with no valid → TRAP, cause 2.
- DECODE: i_opcode ≠ 0010011 → TRAP, cause 1. Otherwise latch rd, rs1, funct3, imm; o_rf_raddr=rs1; → EXECUTE.
- EXECUTE: sext = 32-bit sign-extension of imm. funct3 000 ADDI (mod 2^32), 010 SLTI (signed), 011 SLTIU (unsigned vs sext), 100 XORI, 110 ORI, 111 ANDI, 001 SLLI, 101 SRLI/SRAI, shift amount imm[4:0]. SLLI requires imm[11:5]=0000000; funct3 101 requires 0000000 (logical) or 0100000 (arithmetic); otherwise TRAP cause 1. Result registered; → WRITEBACK.
- WRITEBACK: o_rf_we=1 unless rd=0 (x0 never written); o_pc += 4 (wraps at 2^32); → FETCH.
- TRAP: o_trap=1, o_pc holds faulting instruction's address, no requests or writes; exits only via reset.
- i_imem_valid outside FETCH ignored.

## Timing
- Reset (async, immediate): state IDLE, o_pc=RESET_PC, o_instruction=0, o_imem_req=0, o_rf_we=0, o_rf_waddr=0, o_rf_wdata=0, o_rf_raddr=0, o_busy=0, o_trap=0, o_trap_cause=0.
- Reset mid-FETCH drops o_imem_req asynchronously; any in-flight response is discarded.
- Zero-wait memory: 4 cycles per instruction (FETCH, DECODE, EXECUTE, WRITEBACK); each wait cycle adds one FETCH cycle.
- o_imem_addr stable for the whole FETCH phase.
- o_rf_we/waddr/wdata valid exactly during the WRITEBACK cycle; o_pc updates at the end of it.
- Timeout: trap entered on the clock edge ending the TIMEOUT_CYCLES-th consecutive FETCH cycle without valid.
- Illegal-opcode trap is entered at the end of DECODE; an illegal shift encoding traps at the end of EXECUTE.

## Configuration
- RETIRE_COUNT_EN defined: adds output o_retired (32 bits, reset 0), which increments once per WRITEBACK cycle (including rd=0) and wraps at 2^32.
- Not defined: port and counter absent; all other behaviour identical.

## Test plan
- Reset, i_start, zero-wait fetch of 32'h00000013 → o_rf_we stays 0, o_pc 0→4 after 4 cycles, next FETCH at addr 4.
- 32'h00108093 with x1=5 → WRITEBACK cycle has o_rf_waddr=1, o_rf_wdata=6, o_rf_we=1.
- 32'hFFFF8113 with x31=0 → o_rf_waddr=2, o_rf_wdata=32'hFFFFFFFF.
- Valid delayed 3 cycles → o_imem_req high with o_imem_addr constant for 4 cycles; instruction latched only on the valid cycle; total 7 cycles.
- 32'h00000033 fetched → o_trap=1, cause=1 after DECODE, o_pc=0, no writes, i_start ignored.
- No valid, TIMEOUT_CYCLES=16 → trap cause 2 after 16 FETCH cycles, o_imem_req=0; then async reset clears it.
